oam_dma: RTL and testbench

- Sprite OAM DMA engine inside tarunes_top, sitting on the CPU bus between the 6502 core (cpu_inst) and the memory/PPU bus.
- A CPU write to $4014 starts the transfer: the block halts the CPU and copies page $XX00-$XXFF, byte by byte, to PPU OAMDATA ($2004).
- Standard NES timing: 513 or 514 CPU cycles, depending on cycle parity.

---
 rtl/tarunes_pkg.sv | 16 +
 rtl/oam_dma.sv | 140 ++++++++++++++
 tb/tb_oam_dma.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/tarunes_pkg.sv
// Shared tarunes definitions: CPU-visible register addresses and the OAM DMA state encoding.
package tarunes_pkg;

  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;
  localparam int          OAM_XFER_LEN = 256;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } oam_dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite OAM DMA: a $4014 write halts the CPU for 513/514 CPU cycles and copies page $XX00-$XXFF to $2004.
// Optional macro OAM_DMA_CYCLE_COUNT_EN adds last_len, the ce-cycle length of the most recent transfer.
module oam_dma
  import tarunes_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAMDMA,
  parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA,
  parameter int          XFER_LEN      = OAM_XFER_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_we,
  output logic [7:0]  dma_wdata,
`ifdef OAM_DMA_CYCLE_COUNT_EN
  output logic [9:0]  last_len,
`endif
  input  logic [7:0]  dma_rdata
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  oam_dma_state_t state, state_nxt;
  logic        parity;
  logic [7:0]  page, page_nxt;
  logic [7:0]  idx, idx_nxt;
  logic [15:0] addr_nxt;
  logic        we_nxt;
  logic [7:0]  wdata_nxt;
  logic        rdy_nxt;
  logic        active_nxt;

  // Outputs are registered from the next state so the bus sees them in the cycle the state is current.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      parity     <= 1'b0;
      page       <= 8'h00;
      idx        <= 8'h00;
      cpu_rdy    <= 1'b1;
      dma_active <= 1'b0;
      dma_addr   <= 16'h0000;
      dma_we     <= 1'b0;
      dma_wdata  <= 8'h00;
    end else if (cpu_ce) begin
      state      <= state_nxt;
      parity     <= ~parity;
      page       <= page_nxt;
      idx        <= idx_nxt;
      cpu_rdy    <= rdy_nxt;
      dma_active <= active_nxt;
      dma_addr   <= addr_nxt;
      dma_we     <= we_nxt;
      dma_wdata  <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    page_nxt   = page;
    idx_nxt    = idx;
    wdata_nxt  = dma_wdata;
    addr_nxt   = 16'h0000;
    we_nxt     = 1'b0;
    rdy_nxt    = 1'b1;
    active_nxt = 1'b0;

    // Only IDLE looks at the trigger, so a stale $4014 strobe mid-transfer cannot restart it.
    case (state)
      IDLE: begin
        if (cpu_we && cpu_addr == DMA_REG_ADDR) begin
          page_nxt  = cpu_wdata;
          idx_nxt   = 8'h00;
          state_nxt = HALT;
        end
      end
      HALT:  state_nxt = parity ? ALIGN : READ;
      ALIGN: state_nxt = READ;
      READ: begin
        wdata_nxt = dma_rdata;
        state_nxt = WRITE;
      end
      WRITE: begin
        if (idx == LAST_IDX) begin
          state_nxt = IDLE;
        end else begin
          idx_nxt   = idx + 8'd1;
          state_nxt = READ;
        end
      end
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      HALT, ALIGN: begin
        rdy_nxt    = 1'b0;
        active_nxt = 1'b1;
      end
      READ: begin
        rdy_nxt    = 1'b0;
        active_nxt = 1'b1;
        addr_nxt   = {page_nxt, idx_nxt};
      end
      WRITE: begin
        rdy_nxt    = 1'b0;
        active_nxt = 1'b1;
        addr_nxt   = OAM_DATA_ADDR;
        we_nxt     = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef OAM_DMA_CYCLE_COUNT_EN
  logic [9:0] cyc_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt  <= 10'd0;
      last_len <= 10'd0;
    end else if (cpu_ce) begin
      if (state == IDLE) begin
        cyc_cnt <= 10'd0;
      end else if (state == WRITE && idx == LAST_IDX) begin
        last_len <= cyc_cnt + 10'd1;
        cyc_cnt  <= 10'd0;
      end else begin
        cyc_cnt <= cyc_cnt + 10'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: random memory and pages checked against a transfer-level reference model.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic        cpu_rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_we;
  logic [7:0]  dma_wdata;
  logic [7:0]  dma_rdata;
`ifdef OAM_DMA_CYCLE_COUNT_EN
  logic [9:0]  last_len;
`endif

  logic [7:0] mem [0:65535];
  int total = 0;
  int bad = 0;
  int ce_div = 1;
  int ce_count = 0;

  assign dma_rdata = mem[dma_addr];

  always #5 clk = ~clk;

  oam_dma dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce     (cpu_ce),
    .cpu_addr   (cpu_addr),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdy    (cpu_rdy),
    .dma_active (dma_active),
    .dma_addr   (dma_addr),
    .dma_we     (dma_we),
    .dma_wdata  (dma_wdata),
`ifdef OAM_DMA_CYCLE_COUNT_EN
    .last_len   (last_len),
`endif
    .dma_rdata  (dma_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One CPU cycle: cpu_ce high for one clock, then low for ce_div-1 clocks.
  task automatic ce_step();
    cpu_ce = 1'b1;
    @(posedge clk); #1;
    cpu_ce = 1'b0;
    ce_count++;
    for (int i = 1; i < ce_div; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic align_parity(input int want);
    if ((ce_count % 2) != want) ce_step();
  endtask

  // Trigger a transfer and check it against the model: 256 reads of page:i in order,
  // each followed by a $2004 write of mem[page:i]; halted for 513 (odd start) or 514 cycles.
  task automatic run_dma(input logic [7:0] page, input bit stale, input string tag,
                         output logic [15:0] last_rd, output logic [7:0] first_wr,
                         output logic [7:0] last_wr);
    logic [15:0] rd_q[$];
    logic [7:0]  wr_q[$];
    int halt, first_rd, bad_wa, bad_act, bad_rd, bad_wr, exp_halt;
    halt = 0; first_rd = -1; bad_wa = 0; bad_act = 0; bad_rd = 0; bad_wr = 0;
    exp_halt = (ce_count % 2 == 1) ? 513 : 514;
    cpu_addr  = 16'h4014;
    cpu_we    = 1'b1;
    cpu_wdata = page;
    ce_step();
    if (stale) cpu_wdata = ~page;
    else cpu_we = 1'b0;
    for (int b = 0; b < 700 && cpu_rdy !== 1'b1; b++) begin
      if (dma_we === 1'b1) begin
        wr_q.push_back(dma_wdata);
        if (dma_addr !== 16'h2004) bad_wa++;
      end else if (dma_addr != 16'h0000) begin
        rd_q.push_back(dma_addr);
        if (first_rd < 0) first_rd = halt;
      end
      if (dma_active !== 1'b1) bad_act++;
      halt++;
      ce_step();
    end
    cpu_we = 1'b0;
    for (int i = 0; i < rd_q.size(); i++)
      if (rd_q[i] !== {page, 8'(i)}) bad_rd++;
    for (int i = 0; i < wr_q.size(); i++)
      if (wr_q[i] !== mem[{page, 8'(i)}]) bad_wr++;
    chk({tag, " halt_len"}, halt, exp_halt);
    chk({tag, " first_read_pos"}, first_rd, (exp_halt == 513) ? 1 : 2);
    chk({tag, " n_reads"}, rd_q.size(), 256);
    chk({tag, " n_writes"}, wr_q.size(), 256);
    chk({tag, " read_order_errs"}, bad_rd, 0);
    chk({tag, " write_data_errs"}, bad_wr, 0);
    chk({tag, " write_addr_errs"}, bad_wa, 0);
    chk({tag, " active_errs"}, bad_act, 0);
    chk({tag, " active_after"}, dma_active, 1'b0);
`ifdef OAM_DMA_CYCLE_COUNT_EN
    chk({tag, " last_len"}, last_len, exp_halt);
`endif
    last_rd  = (rd_q.size() > 0) ? rd_q[rd_q.size()-1] : 16'hxxxx;
    first_wr = (wr_q.size() > 0) ? wr_q[0] : 8'hxx;
    last_wr  = (wr_q.size() > 0) ? wr_q[wr_q.size()-1] : 8'hxx;
  endtask

  initial begin
    logic [15:0] lrd;
    logic [7:0]  fwr, lwr;
    int b;

    rst = 1'b0; cpu_ce = 1'b0; cpu_addr = 16'h0; cpu_we = 1'b0; cpu_wdata = 8'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst cpu_rdy", cpu_rdy, 1'b1);
    chk("rst dma_active", dma_active, 1'b0);
    chk("rst dma_addr", dma_addr, 16'h0);
    chk("rst dma_we", dma_we, 1'b0);
    chk("rst dma_wdata", dma_wdata, 8'h0);
`ifdef OAM_DMA_CYCLE_COUNT_EN
    chk("rst last_len", last_len, 10'd0);
`endif
    rst = 1'b1;
    ce_count = 0;

    align_parity(1);
    run_dma(8'h02, 1'b0, "odd_p02", lrd, fwr, lwr);
    align_parity(0);
    run_dma(8'h02, 1'b0, "even_p02", lrd, fwr, lwr);

    for (int a = 16'hFF00; a <= 16'hFFFF; a++) mem[a] = 8'(a) ^ 8'h5A;
    run_dma(8'hFF, 1'b0, "page_ff", lrd, fwr, lwr);
    chk("page_ff last_read", lrd, 16'hFFFF);
    chk("page_ff first_wdata", fwr, 8'h5A);
    chk("page_ff last_wdata", lwr, 8'hA5);

    ce_div = 3;
    align_parity(1);
    run_dma(8'($urandom_range(1, 254)), 1'b0, "div3_odd", lrd, fwr, lwr);
    align_parity(0);
    run_dma(8'($urandom_range(1, 254)), 1'b0, "div3_even", lrd, fwr, lwr);
    ce_div = 1;

    run_dma(8'h37, 1'b1, "stale_strobe", lrd, fwr, lwr);

    cpu_addr = 16'h4015; cpu_we = 1'b1; cpu_wdata = 8'h02;
    ce_step();
    cpu_addr = 16'h4014; cpu_we = 1'b0;
    ce_step();
    for (int i = 0; i < 4; i++) begin
      chk("nostart cpu_rdy", cpu_rdy, 1'b1);
      chk("nostart dma_active", dma_active, 1'b0);
      ce_step();
    end

    cpu_addr = 16'h4014; cpu_we = 1'b1; cpu_wdata = 8'h02;
    ce_step();
    cpu_we = 1'b0;
    for (b = 0; b < 400 && dma_addr !== 16'h0264; b++) ce_step();
    chk("midrst reached_0264", dma_addr, 16'h0264);
    rst = 1'b0;
    #1;
    chk("midrst cpu_rdy", cpu_rdy, 1'b1);
    chk("midrst dma_active", dma_active, 1'b0);
    chk("midrst dma_addr", dma_addr, 16'h0);
    chk("midrst dma_we", dma_we, 1'b0);
    chk("midrst dma_wdata", dma_wdata, 8'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    ce_count = 0;
    run_dma(8'h02, 1'b0, "after_rst", lrd, fwr, lwr);

    for (int t = 0; t < 3; t++) begin
      ce_div = $urandom_range(1, 3);
      repeat ($urandom_range(0, 3)) ce_step();
      run_dma(8'($urandom_range(1, 255)), 1'($urandom), $sformatf("rand%0d", t), lrd, fwr, lwr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
